// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_clk_ctrl                                                  |
// | Purpose  : Execution-clock controller for the single-cycle RV32I core.   |
// |            Emits a one-cycle clock-enable pulse (o_ce) in the system     |
// |            clock domain at a run-time programmable rate, and sequences   |
// |            it through halt, free-run and single-step from debounced      |
// |            board inputs and core halt requests.                          |
// |                                                                          |
// | Ports    : i_clk       system clock (50 MHz)                             |
// |            i_reset     asynchronous active-low reset                     |
// |            i_run_sw    raw run switch (asynchronous)                     |
// |            i_step_btn  raw single-step button (asynchronous)             |
// |            i_halt_req  level halt request from the core (synchronous)    |
// |            i_div_wr    one-cycle strobe loading i_div_val                |
// |            i_div_val   new divide ratio (0 is stored as 1)               |
// |            o_ce        core clock-enable, one cycle per core step        |
// |            o_running   high while in RUN                                 |
// |            o_halted    sticky halt flag, cleared by run-switch fall      |
// |            o_ce_count  number of o_ce pulses issued (wrapping)           |
// |                                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cpu_clk_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 250000,
  parameter int DEBOUNCE    = 500000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run_sw,
  input  logic             i_step_btn,
  input  logic             i_halt_req,
  input  logic             i_div_wr,
  input  logic [CNT_W-1:0] i_div_val,
  output logic             o_ce,
  output logic             o_running,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_ce_count
);

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  localparam int N_IN     = 2;
  localparam int IDX_RUN  = 0;
  localparam int IDX_STEP = 1;

  // Last count value before a debounced level is accepted.
  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE - 1);
  // A zero default ratio would never reach terminal count; clamp to 1.
  localparam logic [CNT_W-1:0] C_DIV_RST =
      (DEFAULT_DIV < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // ------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer + debouncer per raw input
  // ------------------------------------------------------------------------
  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] db;          // accepted (debounced) levels
  logic [N_IN-1:0] db_prev_q;   // accepted levels one cycle earlier

  assign raw[IDX_RUN]  = i_run_sw;
  assign raw[IDX_STEP] = i_step_btn;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_cond
    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] dbcnt_q;
    logic [CNT_W-1:0] dbcnt_d;

    // The count only advances while the synchronized input disagrees with
    // the accepted level; any agreement (a bounce back) restarts it at 0.
    always_comb begin
      db_d    = db_q;
      dbcnt_d = '0;
      if (sync2_q != db_q) begin
        if (dbcnt_q == C_DB_LAST) begin
          db_d = sync2_q;
        end else begin
          dbcnt_d = dbcnt_q + C_ONE;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        dbcnt_q <= '0;
      end else begin
        sync1_q <= raw[gi];
        sync2_q <= sync1_q;
        db_q    <= db_d;
        dbcnt_q <= dbcnt_d;
      end
    end

    assign db[gi] = db_q;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      db_prev_q <= '0;
    end else begin
      db_prev_q <= db;
    end
  end

  logic run_db;
  logic step_rise;
  logic run_fall;

  assign run_db    = db[IDX_RUN];
  assign step_rise = db[IDX_STEP] & ~db_prev_q[IDX_STEP];
  assign run_fall  = ~db[IDX_RUN] & db_prev_q[IDX_RUN];

  // ------------------------------------------------------------------------
  // Divider and sequencing FSM
  // ------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_wr_val;
  logic             term_cnt;

  assign div_wr_val = (i_div_val == '0) ? C_ONE : i_div_val;
  assign term_cnt   = (cnt_q == (div_q - C_ONE));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_HALT;
      div_q      <= C_DIV_RST;
      cnt_q      <= '0;
      o_ce       <= 1'b0;
      o_running  <= 1'b0;
      o_halted   <= 1'b0;
      o_ce_count <= '0;
    end else begin
      o_ce <= 1'b0;

      // A write restarts the phase; later assignments in RUN never touch
      // cnt_q in a write cycle, so the write always wins over terminal count.
      if (i_div_wr) begin
        div_q <= div_wr_val;
        cnt_q <= '0;
      end

      // Clearing on run_fall takes precedence over a coincident halt request.
      if (run_fall) begin
        o_halted <= 1'b0;
      end else if ((state_q == ST_RUN) && i_halt_req) begin
        o_halted <= 1'b1;
      end

      case (state_q)
        ST_HALT: begin
          if (run_db && !o_halted) begin
            // A step arriving on the entry cycle is deliberately dropped.
            state_q   <= ST_RUN;
            o_running <= 1'b1;
            cnt_q     <= '0;
          end else if (step_rise) begin
            o_ce       <= 1'b1;
            o_ce_count <= o_ce_count + C_ONE;
          end
        end

        ST_RUN: begin
          if (!run_db || i_halt_req) begin
            // Leaving RUN suppresses any pulse due on this edge.
            state_q   <= ST_HALT;
            o_running <= 1'b0;
          end else if (!i_div_wr) begin
            if (term_cnt) begin
              cnt_q      <= '0;
              o_ce       <= 1'b1;
              o_ce_count <= o_ce_count + C_ONE;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
        end

        default: begin
          state_q   <= ST_HALT;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_clk_ctrl                                               |
// | Purpose  : Self-checking bench for cpu_clk_ctrl. A behavioural model     |
// |            tracks debounced levels as a sliding window of raw samples    |
// |            and pulse timing as a phase origin plus modulo arithmetic.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cpu_clk_ctrl;

  localparam int CNT_W   = 32;
  localparam int DEF_DIV = 4;
  localparam int DB      = 3;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             run_sw   = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt_req = 1'b0;
  logic             div_wr   = 1'b0;
  logic [CNT_W-1:0] div_val  = '0;
  logic             ce;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] ce_count;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEF_DIV),
    .DEBOUNCE   (DB)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_run_sw  (run_sw),
    .i_step_btn(step_btn),
    .i_halt_req(halt_req),
    .i_div_wr  (div_wr),
    .i_div_val (div_val),
    .o_ce      (ce),
    .o_running (running),
    .o_halted  (halted),
    .o_ce_count(ce_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  int          t;         // edges since reset release
  bit          m_run;
  bit          m_halted;
  bit          m_ce;
  int          m_div;
  int          m_origin;  // edge at which the current period started
  logic [31:0] m_count;
  bit          m_run_db, m_run_db_prev;
  bit          m_step_db, m_step_db_prev;
  logic [DB+1:0] run_h, step_h;  // bit k = raw sample taken k edges ago

  // The debouncer at an edge sees the raw value from two edges earlier; a
  // level is accepted once the last DB such samples all disagree with it.
  function automatic bit db_next(bit cur, logic [DB+1:0] h);
    logic [DB-1:0] win;
    win = h[DB+1:2];
    if (cur) return (win == '0) ? 1'b0 : 1'b1;
    else     return (&win) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    t = 0; m_run = 0; m_halted = 0; m_ce = 0; m_div = DEF_DIV; m_origin = 0;
    m_count = '0; m_run_db = 0; m_run_db_prev = 0; m_step_db = 0;
    m_step_db_prev = 0; run_h = '0; step_h = '0;
  endtask

  task automatic model_edge(bit r, bit s, bit h, bit w, logic [31:0] v);
    bit rise, fall, was_run;
    t++;
    rise    = m_step_db && !m_step_db_prev;
    fall    = !m_run_db && m_run_db_prev;
    was_run = m_run;
    m_ce    = 0;
    if (was_run) begin
      if (!m_run_db || h)                       m_run = 0;
      else if (w)                               m_origin = t;
      else if (((t - m_origin) % m_div) == 0)   m_ce = 1;
    end else begin
      if (m_run_db && !m_halted) begin m_run = 1; m_origin = t; end
      else if (rise)                 m_ce = 1;
    end
    if (fall)                 m_halted = 0;
    else if (was_run && h)    m_halted = 1;
    if (w) m_div = (v == 0) ? 1 : int'(v);
    if (m_ce) m_count = m_count + 32'd1;
    m_run_db_prev  = m_run_db;
    m_step_db_prev = m_step_db;
    run_h  = {run_h[DB:0], r};
    step_h = {step_h[DB:0], s};
    m_run_db  = db_next(m_run_db, run_h);
    m_step_db = db_next(m_step_db, step_h);
  endtask

  // True when the coming edge is a terminal-count edge with RUN sustained.
  function automatic bit tc_next();
    return m_run && m_run_db && (((t + 1 - m_origin) % m_div) == 0);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic tick();
    bit r, s, h, w;
    logic [31:0] v;
    r = run_sw; s = step_btn; h = halt_req; w = div_wr; v = div_val;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) model_reset();
    else        model_edge(r, s, h, w, v);
    chk("ce",       32'(ce),       32'(m_ce));
    chk("running",  32'(running),  32'(m_run));
    chk("halted",   32'(halted),   32'(m_halted));
    chk("ce_count", ce_count,      m_count);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_tc();
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (tc_next()) begin found = 1; break; end
      tick();
    end
    chk("tc_found", 32'(found), 32'd1);
  endtask

  task automatic write_div(logic [31:0] v);
    div_wr = 1; div_val = v;
    tick();
    div_wr = 0;
  endtask

  // Button press with two 2-cycle bounces, then a 20-cycle hold and release.
  task automatic press_step(output int pulses);
    pulses = 0;
    for (int b = 0; b < 2; b++) begin
      step_btn = 1; tick(); if (ce) pulses++; tick(); if (ce) pulses++;
      step_btn = 0; tick(); if (ce) pulses++; tick(); if (ce) pulses++;
    end
    step_btn = 1;
    for (int i = 0; i < 20; i++) begin tick(); if (ce) pulses++; end
    step_btn = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ce) pulses++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last, pulses;
    logic [31:0] cnt0;
    model_reset();

    // Reset state
    ticks(3);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", ce_count, 32'd0);

    // Release with run switch on; RUN after sync(2) + debounce(3) + 1
    run_sw = 1; rst_n = 1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin tick(); if (running) begin n = i; break; end end
    chk("rel_to_run", n, 32'd6);

    // Run cadence
    last = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ce) begin
        if (last >= 0) chk("ce_gap", 32'(cyc - last), 32'd4);
        last = cyc;
      end
    end

    // Reset mid-RUN with cnt = 2
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_run && (((t - m_origin) % m_div) == 2)) begin n = 1; break; end
      tick();
    end
    chk("phase2_found", n, 32'd1);
    #2; rst_n = 0; #1;
    chk("arst_ce", 32'(ce), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_count", ce_count, 32'd0);
    model_reset();
    ticks(2);
    rst_n = 1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin tick(); if (running) begin n = i; break; end end
    chk("rerel_to_run", n, 32'd6);
    n = -1;
    for (int i = 1; i <= 10; i++) begin tick(); if (ce) begin n = i; break; end end
    chk("first_ce", n, 32'd4);

    // Divider writes: 2, then 0 (every cycle), then a write on terminal count
    write_div(32'd2);
    ticks(12);
    write_div(32'd0);
    for (int i = 0; i < 8; i++) begin tick(); chk("div1_ce", 32'(ce), 32'd1); end
    write_div(32'd3);
    ticks(2);
    wait_tc();
    write_div(32'($urandom_range(2, 5)));
    chk("wr_tc_ce", 32'(ce), 32'd0);
    for (int k = 0; k < 6; k++) begin
      ticks($urandom_range(1, 9));
      write_div(32'($urandom_range(0, 6)));
    end
    write_div(32'($urandom_range(2, 5)));
    ticks(7);

    // Halt request on terminal count
    wait_tc();
    halt_req = 1; tick(); halt_req = 0;
    chk("halt_ce", 32'(ce), 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_running", 32'(running), 32'd0);
    ticks(6);
    run_sw = 0; ticks(8);
    chk("fall_clears", 32'(halted), 32'd0);
    run_sw = 1; ticks(8);
    chk("resume", 32'(running), 32'd1);

    // Single step in HALT while halted
    halt_req = 1; tick(); halt_req = 0;
    cnt0 = ce_count;
    press_step(pulses);
    chk("step_halted_pulses", pulses, 32'd1);
    chk("step_halted_count", ce_count - cnt0, 32'd1);

    // Same press while in RUN (no extra pulse; model tracks cadence)
    run_sw = 0; ticks(8);
    run_sw = 1; ticks(8);
    press_step(pulses);

    // Single step in HALT, not halted
    run_sw = 0; ticks(8);
    cnt0 = ce_count;
    press_step(pulses);
    chk("step_pulses", pulses, 32'd1);
    chk("step_count", ce_count - cnt0, 32'd1);

    // Debounce rejection of 2-cycle run-switch glitches
    for (int g = 0; g < 5; g++) begin
      run_sw = 1; tick(); tick();
      run_sw = 0;
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
    end
    for (int i = 0; i < 6; i++) begin tick(); chk("glitch_running", 32'(running), 32'd0); end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 14) == 0) step_btn = ~step_btn;
      halt_req = ($urandom_range(0, 99) < 3);
      div_wr   = ($urandom_range(0, 29) == 0);
      div_val  = 32'($urandom_range(0, 6));
      tick();
    end
    halt_req = 0; div_wr = 0;
    ticks(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
